i2c_slave_target: RTL and testbench
===================================

// Module: i2c_slave_target
// PURPOSE
//  I2C target (slave) that consumes the SDA/SCL bus driven by the team's I2C master.
//  Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address,
//  ACKs, and either delivers received write bytes or serves read bytes from tx_data.
//  It is the bench/loopback partner for the master and the on-chip endpoint for peripherals.
// PARAMETERS
//  SLAVE_ADDR  7'h50  7-bit bus address this target answers to
//  SYNC_STAGES 2      synchronizer flops on SCL/SDA inputs (legal: 2..3)
// PORTS
//  clk        input  1  system clock; all logic on rising edge
//  reset      input  1  asynchronous, active-low; clears all state
//  SCL        input  1  I2C clock from master (never driven by this block)
//  SDA        inout  1  I2C data; open-drain: driven 1'b0 or released to 1'bz, never driven 1
//  tx_data    input  8  byte returned on the next read byte; sampled when tx_req pulses
//  rx_data    output 8  last byte received in a write transfer
//  rx_valid   output 1  one-clk pulse: rx_data updated
//  tx_req     output 1  one-clk pulse: tx_data captured into the shift register
//  busy       output 1  high from address match until STOP/START/reset
//  addr_match output 1  one-clk pulse on address match (ACK about to drive)
// BEHAVIOUR
//  - Reset (reset==0): state IDLE, SDA released (z), rx_data=0, rx_valid=0, tx_req=0, busy=0, addr_match=0, bit_cnt=0.
//  - Inputs pass SYNC_STAGES flops then one edge-detect flop; bus events seen SYNC_STAGES+1 clks late.
//  - Requires SCL high and low phases each >= 4 clk and SDA stable >= 2 clk around SCL edges.
//  - START: synced SDA 1->0 while SCL high. STOP: SDA 0->1 while SCL high. Both override any state.
//    START (incl. repeated) -> ADDR, bit_cnt=0, SDA released. STOP -> IDLE, SDA released, busy=0.
//  - Data sampled on synced SCL rising edge, MSB first; SDA changed only on synced SCL falling edge.
//  - States:
//    IDLE     : wait for START.
//    ADDR     : shift 8 bits {addr[6:0], rw}. After 8th rising edge: match -> on next falling
//               edge drive SDA=0, pulse addr_match, busy=1, go ADDR_ACK; mismatch -> WAIT_STOP (no ACK).
//    ADDR_ACK : hold SDA=0 through ACK clock; on its falling edge: rw=0 -> release SDA, WR_DATA;
//               rw=1 -> pulse tx_req, load tx_data, drive bit7, RD_DATA.
//    WR_DATA  : shift 8 bits; after 8th rising edge rx_data<=byte, rx_valid pulse (same clk);
//               next falling edge drive ACK -> WR_ACK.
//    WR_ACK   : on ACK falling edge release SDA, bit_cnt=0 -> WR_DATA (unbounded byte count).
//    RD_DATA  : drive shift-reg MSB (0 -> pull low, 1 -> release) on each falling edge;
//               after 8th bit's falling edge release SDA -> RD_ACK.
//    RD_ACK   : sample master ACK on rising edge; ACK(0) -> on falling edge pulse tx_req, reload,
//               RD_DATA; NACK(1) -> WAIT_STOP.
//    WAIT_STOP: SDA released; only START/STOP leave.
//  - bit_cnt 3-bit, wraps 7->0 at byte end; no other counters.
//  - SDA release must occur on the same clk the falling edge is detected (never release while SCL high).
//  - Reset asserted mid-transfer: SDA released immediately (asynchronous), master sees NACK/idle bus.
//  - Simultaneous START and byte completion in one clk: START wins, no rx_valid.
// TESTING
//  1. Write 0x50 W, data 0xA5,0x3C, STOP -> ACK x3, rx_valid twice with rx_data 0xA5 then 0x3C, busy falls after STOP.
//  2. Address 0x51 W -> no ACK (SDA z on 9th clock), no rx_valid, state WAIT_STOP until STOP.
//  3. Read 0x50 R, tx_data=0xC3 then 0x81, master ACK then NACK -> bus bits 11000011,10000001; tx_req x2.
//  4. Write 0x50 W, 0x11, repeated START, 0x50 R -> rx_data=0x11, then read byte served, busy stays 1.
//  5. Drop reset low at bit 4 of a read byte with SDA pulled low -> SDA z same cycle, all outputs reset values.
//  6. STOP injected mid-byte (after 3 data bits) -> IDLE, no rx_valid, busy=0 within SYNC_STAGES+2 clk.

Source files
------------

// File: rtl/i2c_slave_target.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// write-byte delivery and read-byte service over an open-drain SDA.
module i2c_slave_target #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       busy,
  output logic       addr_match
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrData, StWrAck, StRdData, StRdAck, StWaitStop
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] sample;
  // Set after a completed byte (or master ACK): act on the next SCL falling edge.
  logic       pend_q, pend_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;
  logic       addr_match_q, addr_match_d;

  // Open-drain: only ever pull low; a registered enable so async reset releases at once.
  assign SDA = sda_oe_q ? 1'b0 : 1'bz;

  // Synchronize bus inputs, then keep one delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDA};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign sample    = {shift_q[6:0], sda_s};

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      pend_q       <= 1'b0;
      rw_q         <= 1'b0;
      sda_oe_q     <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      tx_req_q     <= 1'b0;
      busy_q       <= 1'b0;
      addr_match_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      pend_q       <= pend_d;
      rw_q         <= rw_d;
      sda_oe_q     <= sda_oe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      tx_req_q     <= tx_req_d;
      busy_q       <= busy_d;
      addr_match_q <= addr_match_d;
    end
  end

  // Next-state logic; START/STOP take priority over anything in flight.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    pend_d       = pend_q;
    rw_d         = rw_q;
    sda_oe_d     = sda_oe_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    tx_req_d     = 1'b0;
    busy_d       = busy_q;
    addr_match_d = 1'b0;
    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      pend_d    = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      pend_d    = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_rise) begin
            shift_d   = sample;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (sample[7:1] == SLAVE_ADDR) begin
                pend_d = 1'b1;
                rw_d   = sample[0];
              end else begin
                state_d = StWaitStop;
              end
            end
          end else if (scl_fall && pend_q) begin
            pend_d       = 1'b0;
            sda_oe_d     = 1'b1;
            addr_match_d = 1'b1;
            busy_d       = 1'b1;
            state_d      = StAddrAck;
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (!rw_q) begin
              sda_oe_d = 1'b0;
              state_d  = StWrData;
            end else begin
              tx_req_d = 1'b1;
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              state_d  = StRdData;
            end
          end
        end
        StWrData: begin
          if (scl_rise) begin
            shift_d   = sample;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = sample;
              rx_valid_d = 1'b1;
              pend_d     = 1'b1;
            end
          end else if (scl_fall && pend_q) begin
            pend_d   = 1'b0;
            sda_oe_d = 1'b1;
            state_d  = StWrAck;
          end
        end
        StWrAck: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = StWrData;
          end
        end
        StRdData: begin
          // Bit 7 was driven on entry; each later fall presents the next bit.
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = StRdAck;
            end else begin
              sda_oe_d = ~shift_q[6];
              shift_d  = {shift_q[6:0], 1'b0};
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            if (sda_s) state_d = StWaitStop;
            else       pend_d  = 1'b1;
          end else if (scl_fall && pend_q) begin
            pend_d    = 1'b0;
            tx_req_d  = 1'b1;
            shift_d   = tx_data;
            sda_oe_d  = ~tx_data[7];
            bit_cnt_d = '0;
            state_d   = StRdData;
          end
        end
        StWaitStop: sda_oe_d = 1'b0;
        default: state_d = StIdle;
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign tx_req     = tx_req_q;
  assign busy       = busy_q;
  assign addr_match = addr_match_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Directed bench for i2c_slave_target: a bit-banged master on a pulled-up SDA line.
module tb_i2c_slave_target;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_m = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy, addr_match;
  wire        SDA;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_cnt   = 0;
  int tx_cnt   = 0;
  int am_cnt   = 0;
  logic [7:0] rx_log [0:7];

  pullup (SDA);
  assign SDA = m_low ? 1'b0 : 1'bz;

  i2c_slave_target #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .SCL        (scl_m),
    .SDA        (SDA),
    .tx_data    (tx_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_req     (tx_req),
    .busy       (busy),
    .addr_match (addr_match)
  );

  always #5 clk = ~clk;

  // Count the one-clock pulses and log received bytes.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt[2:0]] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_req)     tx_cnt <= tx_cnt + 1;
    if (addr_match) am_cnt <= am_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Works from idle (both high) and as a repeated START from SCL low.
  task automatic bus_start();
    m_low = 1'b0; clks(4);
    scl_m = 1'b1; clks(8);
    m_low = 1'b1; clks(8);
    scl_m = 1'b0; clks(4);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; clks(4);
    scl_m = 1'b1; clks(8);
    m_low = 1'b0; clks(8);
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; clks(4);
    scl_m = 1'b1; clks(8);
    scl_m = 1'b0; clks(4);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; clks(4);
    scl_m = 1'b1; clks(4);
    b = SDA;      clks(4);
    scl_m = 1'b0; clks(4);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_bit);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(ack_bit);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         rx0, tx0, am0;

    // Reset state
    clks(3);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_req", tx_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr_match", addr_match, 1'b0);
    chk("rst_sda", SDA, 1'b1);
    reset = 1'b1;
    clks(5);

    // 1: write 0x50, data A5 3C, STOP
    bus_start();
    write_byte(8'hA0, a); chk("t1_addr_ack", a, 1'b0);
    chk("t1_addr_match_cnt", am_cnt, 1);
    chk("t1_busy", busy, 1'b1);
    write_byte(8'hA5, a); chk("t1_d0_ack", a, 1'b0);
    write_byte(8'h3C, a); chk("t1_d1_ack", a, 1'b0);
    chk("t1_rx_cnt", rx_cnt, 2);
    chk("t1_rx0", rx_log[0], 8'hA5);
    chk("t1_rx1", rx_log[1], 8'h3C);
    chk("t1_rx_data", rx_data, 8'h3C);
    bus_stop();
    chk("t1_busy_after_stop", busy, 1'b0);

    // 2: wrong address 0x51 -> no ACK, ignored until STOP
    bus_start();
    write_byte(8'hA2, a); chk("t2_addr_nack", a, 1'b1);
    write_byte(8'h12, a); chk("t2_data_nack", a, 1'b1);
    chk("t2_rx_cnt", rx_cnt, 2);
    chk("t2_am_cnt", am_cnt, 1);
    chk("t2_busy", busy, 1'b0);
    bus_stop();

    // 3: read 0x50, C3 (ACK) then 81 (NACK)
    tx_data = 8'hC3;
    tx0 = tx_cnt;
    bus_start();
    write_byte(8'hA1, a); chk("t3_addr_ack", a, 1'b0);
    tx_data = 8'h81;
    read_byte(1'b0, d); chk("t3_byte0", d, 8'hC3);
    read_byte(1'b1, d); chk("t3_byte1", d, 8'h81);
    chk("t3_tx_req_cnt", tx_cnt - tx0, 2);
    chk("t3_sda_released", SDA, 1'b1);
    bus_stop();
    chk("t3_busy_after_stop", busy, 1'b0);

    // 4: write 0x11, repeated START, read 0x5A
    bus_start();
    write_byte(8'hA0, a); chk("t4_addr_w_ack", a, 1'b0);
    write_byte(8'h11, a); chk("t4_data_ack", a, 1'b0);
    chk("t4_rx_data", rx_data, 8'h11);
    tx_data = 8'h5A;
    bus_start();
    write_byte(8'hA1, a); chk("t4_addr_r_ack", a, 1'b0);
    read_byte(1'b1, d); chk("t4_read_byte", d, 8'h5A);
    chk("t4_busy", busy, 1'b1);
    bus_stop();

    // 5: reset mid read byte with SDA pulled low
    tx_data = 8'h00;
    bus_start();
    write_byte(8'hA1, a); chk("t5_addr_ack", a, 1'b0);
    for (int i = 0; i < 4; i++) read_bit(a);
    m_low = 1'b0; clks(4);
    chk("t5_sda_low_before", SDA, 1'b0);
    reset = 1'b0; #1;
    chk("t5_sda_released", SDA, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_rx_data", rx_data, 8'h00);
    chk("t5_tx_req", tx_req, 1'b0);
    chk("t5_addr_match", addr_match, 1'b0);
    scl_m = 1'b1;
    clks(4);
    reset = 1'b1;
    clks(6);

    // 6: STOP after 3 data bits of a write byte
    rx0 = rx_cnt;
    am0 = am_cnt;
    bus_start();
    write_byte(8'hA0, a); chk("t6_addr_ack", a, 1'b0);
    chk("t6_am_cnt", am_cnt - am0, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    m_low = 1'b1; clks(4);
    scl_m = 1'b1; clks(8);
    m_low = 1'b0; clks(4);
    chk("t6_busy", busy, 1'b0);
    chk("t6_no_rx_valid", rx_cnt - rx0, 0);
    chk("t6_sda_released", SDA, 1'b1);
    clks(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
